bit_serial_counter: RTL and testbench

BIT_SERIAL_COUNTER -- requirements
Module: bit_serial_counter

---
 rtl/bit_serial_counter.sv | 116 +++++++++++
 tb/tb_bit_serial_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bit_serial_counter.sv
// bit_serial_counter: tick-driven up-counter with a latched terminal count.
// A start launches a sequence that advances on each effective step until the
// count matches the latched terminal value, then pulses done and goes idle.
// Optional feature macro: BIT_SERIAL_COUNTER_PRESCALE_EN. When defined, only
// every PRESCALE-th tick in RUN is an effective step.
module bit_serial_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             one,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             done_q,  done_d;
  logic             step;

`ifdef BIT_SERIAL_COUNTER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Prescaler: counts ticks in RUN, fires a step on the PRESCALE-th one.
  always_comb begin
    presc_d = presc_q;
    step    = 1'b0;
    if (clear || start) begin
      presc_d = '0;
    end else if (tick && (state_q == RUN)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  // Every tick in RUN is an effective step.
  always_comb begin
    step = tick && (state_q == RUN);
  end
`endif

  // Next-state logic: priority clear > start > effective step.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      term_d  = term;
    end else if (step) begin
      if (count_q == term_q) begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '1;
      term_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      done_q  <= done_d;
    end
  end

  // Output decodes of registered state.
  always_comb begin
    count = count_q;
    busy  = (state_q == RUN);
    done  = done_q;
    one   = &count_q;
    zero  = ~|count_q;
  end

endmodule

// File: tb/tb_bit_serial_counter.sv
// Testbench for bit_serial_counter (WIDTH=3, PRESCALE=4).
// Expected outputs are pushed to a scoreboard queue as each cycle's stimulus
// is driven and popped/compared after the clock edge that produces them.
module tb_bit_serial_counter;

  logic       clk = 1'b0;
  logic       rst, start, clear, tick;
  logic [2:0] term;
  logic [2:0] count;
  logic       busy, one, zero, done;

  typedef struct packed {
    logic [2:0] count;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  bit_serial_counter #(
    .WIDTH    (3),
    .PRESCALE (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clear (clear),
    .tick  (tick),
    .term  (term),
    .count (count),
    .busy  (busy),
    .one   (one),
    .zero  (zero),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of stimulus, queue its expected result, check after the edge.
  task automatic cyc(input logic rs, input logic st, input logic cl, input logic tk,
                     input logic [2:0] tm, input logic [2:0] ec, input logic eb,
                     input logic ed, input string nm);
    exp_t e;
    exp_t got;
    string n;
    bit bad;
    rst = rs; start = st; clear = cl; tick = tk; term = tm;
    e.count = ec; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    got.count = count; got.busy = busy; got.done = done;
    bad = 1'b0;
    vectors++;
    if (got.count !== e.count) begin
      $display("FAIL %s count: got %0d expected %0d", n, got.count, e.count); bad = 1'b1;
    end
    if (got.busy !== e.busy) begin
      $display("FAIL %s busy: got %b expected %b", n, got.busy, e.busy); bad = 1'b1;
    end
    if (got.done !== e.done) begin
      $display("FAIL %s done: got %b expected %b", n, got.done, e.done); bad = 1'b1;
    end
    if (one !== (e.count == 3'd7)) begin
      $display("FAIL %s one: got %b expected %b", n, one, (e.count == 3'd7)); bad = 1'b1;
    end
    if (zero !== (e.count == 3'd0)) begin
      $display("FAIL %s zero: got %b expected %b", n, zero, (e.count == 3'd0)); bad = 1'b1;
    end
    if (bad) miscompares++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 3'd0, 3'd7, 0, 0, "reset");
    cyc(0, 0, 0, 1, 3'd0, 3'd7, 0, 0, "reset_idle_tick");
  endtask

  task automatic test_count();
    cyc(0, 1, 0, 0, 3'd5, 3'd0, 1, 0, "cnt_start");
    for (int unsigned i = 1; i <= 5; i++)
      cyc(0, 0, 0, 1, 3'd5, 3'(i), 1, 0, "cnt_tick");
    cyc(0, 0, 0, 1, 3'd5, 3'd0, 0, 1, "cnt_end");
    cyc(0, 0, 0, 1, 3'd5, 3'd0, 0, 0, "cnt_done_drop");
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 0, 3'd7, 3'd0, 1, 0, "wrap_start");
    for (int unsigned i = 1; i <= 7; i++)
      cyc(0, 0, 0, 1, 3'd0, 3'(i), 1, 0, "wrap_tick");
    cyc(0, 0, 0, 1, 3'd0, 3'd0, 0, 1, "wrap_end");
    cyc(0, 0, 0, 0, 3'd0, 3'd0, 0, 0, "wrap_done_drop");
    cyc(0, 1, 0, 0, 3'd0, 3'd0, 1, 0, "term0_start");
    cyc(0, 0, 0, 1, 3'd0, 3'd0, 0, 1, "term0_tick");
    cyc(0, 0, 0, 0, 3'd0, 3'd0, 0, 0, "term0_done_drop");
  endtask

  task automatic test_clear();
    cyc(0, 1, 0, 0, 3'd5, 3'd0, 1, 0, "clr_start");
    for (int unsigned i = 1; i <= 3; i++)
      cyc(0, 0, 0, 1, 3'd5, 3'(i), 1, 0, "clr_tick");
    cyc(0, 0, 1, 1, 3'd5, 3'd0, 0, 0, "clr_with_tick");
    cyc(0, 0, 0, 1, 3'd5, 3'd0, 0, 0, "clr_after");
    cyc(0, 1, 0, 0, 3'd5, 3'd0, 1, 0, "st_tick_start");
    cyc(0, 0, 0, 1, 3'd5, 3'd1, 1, 0, "st_tick_t1");
    cyc(0, 0, 0, 1, 3'd5, 3'd2, 1, 0, "st_tick_t2");
    cyc(0, 1, 0, 1, 3'd5, 3'd0, 1, 0, "start_and_tick");
    cyc(0, 1, 1, 1, 3'd5, 3'd0, 0, 0, "clear_over_start");
  endtask

  task automatic test_term_change();
    cyc(0, 1, 0, 0, 3'd4, 3'd0, 1, 0, "term_start");
    cyc(0, 0, 0, 1, 3'd4, 3'd1, 1, 0, "term_t1");
    cyc(0, 0, 0, 1, 3'd4, 3'd2, 1, 0, "term_t2");
    cyc(0, 0, 0, 1, 3'd1, 3'd3, 1, 0, "term_t3");
    cyc(0, 0, 0, 1, 3'd1, 3'd4, 1, 0, "term_t4");
    cyc(0, 0, 0, 1, 3'd1, 3'd0, 0, 1, "term_t5_end");
    cyc(0, 1, 0, 0, 3'd5, 3'd0, 1, 0, "rst_run_start");
    cyc(0, 0, 0, 1, 3'd5, 3'd1, 1, 0, "rst_run_t1");
    cyc(0, 0, 0, 1, 3'd5, 3'd2, 1, 0, "rst_run_t2");
    cyc(1, 0, 0, 1, 3'd5, 3'd7, 0, 0, "rst_mid_run");
    cyc(0, 0, 0, 1, 3'd5, 3'd7, 0, 0, "rst_mid_after");
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, 0, 0, 3'd3, 3'd0, 1, 0, "b2b_start");
    cyc(0, 0, 0, 1, 3'd3, 3'd1, 1, 0, "b2b_t1");
    cyc(0, 1, 0, 0, 3'd2, 3'd0, 1, 0, "b2b_restart");
    cyc(0, 0, 0, 1, 3'd6, 3'd1, 1, 0, "b2b_t2");
    cyc(0, 0, 0, 1, 3'd6, 3'd2, 1, 0, "b2b_t3");
    cyc(0, 0, 0, 1, 3'd6, 3'd0, 0, 1, "b2b_end");
    cyc(0, 1, 0, 0, 3'd1, 3'd0, 1, 0, "b2b_start_after_done");
    cyc(0, 0, 0, 1, 3'd1, 3'd1, 1, 0, "b2b_t4");
    cyc(0, 0, 0, 1, 3'd1, 3'd0, 0, 1, "b2b_end2");
  endtask

  task automatic test_prescale();
    cyc(0, 1, 0, 0, 3'd2, 3'd0, 1, 0, "psc_start");
    for (int unsigned k = 1; k <= 11; k++)
      cyc(0, 0, 0, 1, 3'd2, 3'(k / 4), 1, 0, "psc_tick");
    cyc(0, 0, 0, 1, 3'd2, 3'd0, 0, 1, "psc_end");
    cyc(0, 0, 0, 1, 3'd2, 3'd0, 0, 0, "psc_done_drop");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; tick = 1'b0; term = 3'd0;
    @(negedge clk);
    test_reset();
`ifdef BIT_SERIAL_COUNTER_PRESCALE_EN
    test_prescale();
`else
    test_count();
    test_wrap();
    test_clear();
    test_term_change();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
